seq_fifo_ctrl: RTL

Clocked, parametrised successor to the single-register handshake stage. It is a DEPTH-entry elastic buffer with four-phase (return-to-zero) req/ack handshakes on both sides. Incoming control signals pass through configurable synchronizers, so the block can interface with self-timed stages. It sits between a self-timed producer and consumer, decoupling them by up to DEPTH+1 words (DEPTH storage entries plus one output holding register).

---
 rtl/seq_ctrl_pkg.sv | 12 +
 rtl/sync_bit.sv | 31 +++
 rtl/seq_fifo_ctrl.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/seq_ctrl_pkg.sv
// rtl/seq_ctrl_pkg.sv - shared state types and pointer helper for the sequential FIFO controller
package seq_ctrl_pkg;

   typedef enum logic [1:0] {L_WAIT_LOW, L_IDLE, L_ACK} left_state_t;
   typedef enum logic [1:0] {R_IDLE, R_REQ, R_WAIT} right_state_t;

   // Advance a storage pointer, wrapping from depth-1 back to 0 (depth need not be a power of 2)
   function automatic logic [31:0] ptr_inc(input logic [31:0] ptr, input logic [31:0] depth);
      return (ptr == depth - 32'd1) ? 32'd0 : ptr + 32'd1;
   endfunction

endpackage

// File: rtl/sync_bit.sv
// rtl/sync_bit.sv - STAGES-deep single-bit synchronizer, pass-through when STAGES is 0
module sync_bit #(
   parameter int STAGES = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic d_i,
   output logic q_o
);

   if (STAGES == 0) begin : g_bypass
      logic unused_clk_rst;
      assign unused_clk_rst = clk ^ rst_n;
      assign q_o = d_i;
   end else begin : g_chain
      logic [STAGES-1:0] chain_q;

      // Shift the asynchronous input through the flop chain
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            chain_q <= '0;
         end else begin
            chain_q[0] <= d_i;
            for (int i = 1; i < STAGES; i++) chain_q[i] <= chain_q[i-1];
         end
      end

      assign q_o = chain_q[STAGES-1];
   end

endmodule

// File: rtl/seq_fifo_ctrl.sv
// rtl/seq_fifo_ctrl.sv - DEPTH-entry elastic buffer with four-phase req/ack on both sides
module seq_fifo_ctrl
   import seq_ctrl_pkg::*;
#(
   parameter int WIDTH       = 8,
   parameter int DEPTH       = 4,
   parameter int SYNC_STAGES = 2
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic [WIDTH-1:0]           data_in,
   input  logic                       left_req_in,
   output logic                       left_ack_out,
   output logic [WIDTH-1:0]           data_out,
   output logic                       right_req_out,
   input  logic                       right_ack_in,
   input  logic                       flush,
   output logic [$clog2(DEPTH+1)-1:0] count
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH + 1);
   localparam int SW = (SYNC_STAGES > 0) ? $clog2(SYNC_STAGES + 1) : 1;
   localparam logic [CW-1:0] FULL    = CW'(DEPTH);
   localparam logic [SW-1:0] SETTLED = SW'(SYNC_STAGES);

   left_state_t      l_state_q;
   right_state_t     r_state_q;
   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]    count_q, count_d;
   logic [SW-1:0]    settle_q;
   logic             left_ack_q;
   logic             right_req_q;
   logic [WIDTH-1:0] data_out_q;
   logic             req_s, ack_s, ack_s_q;
   logic             accept, push, pop;

   sync_bit #(.STAGES(SYNC_STAGES)) u_sync_req (
      .clk(clk), .rst_n(reset), .d_i(left_req_in), .q_o(req_s)
   );

   sync_bit #(.STAGES(SYNC_STAGES)) u_sync_ack (
      .clk(clk), .rst_n(reset), .d_i(right_ack_in), .q_o(ack_s)
   );

   // A request accepted during flush is still acknowledged, but its word is dropped
   assign accept = (l_state_q == L_IDLE) && req_s && (count_q < FULL);
   assign push   = accept && !flush;
   assign pop    = (r_state_q == R_IDLE) && (count_q != '0) && !flush;

   // Next pointer and occupancy values; flush empties the storage
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (push) wr_ptr_d = PW'(ptr_inc(32'(wr_ptr_q), 32'(DEPTH)));
         if (pop)  rd_ptr_d = PW'(ptr_inc(32'(rd_ptr_q), 32'(DEPTH)));
         if (push && !pop)      count_d = count_q + CW'(1);
         else if (pop && !push) count_d = count_q - CW'(1);
      end
   end

   // Pointer and occupancy registers
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         ack_s_q  <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         ack_s_q  <= ack_s;
      end
   end

   // Storage write; contents are meaningless until pushed, so no reset
   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q] <= data_in;
   end

   // Producer-side handshake; waits for the synchronizer to hold real samples before trusting req_s
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         l_state_q  <= L_WAIT_LOW;
         left_ack_q <= 1'b0;
         settle_q   <= '0;
      end else begin
         if (settle_q != SETTLED) settle_q <= settle_q + SW'(1);
         case (l_state_q)
            L_WAIT_LOW: if (settle_q == SETTLED && !req_s) l_state_q <= L_IDLE;
            L_IDLE: if (accept) begin
               left_ack_q <= 1'b1;
               l_state_q  <= L_ACK;
            end
            L_ACK: if (!req_s) begin
               left_ack_q <= 1'b0;
               l_state_q  <= L_IDLE;
            end
            default: l_state_q <= L_WAIT_LOW;
         endcase
      end
   end

   // Consumer-side handshake; the output register holds the launched word until the next launch
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state_q   <= R_IDLE;
         right_req_q <= 1'b0;
         data_out_q  <= '0;
      end else begin
         case (r_state_q)
            R_IDLE: if (pop) begin
               data_out_q  <= mem_q[rd_ptr_q];
               right_req_q <= 1'b1;
               r_state_q   <= R_REQ;
            end
            R_REQ: if (ack_s) begin
               right_req_q <= 1'b0;
               r_state_q   <= R_WAIT;
            end
            R_WAIT: if (!ack_s) r_state_q <= R_IDLE;
            default: r_state_q <= R_IDLE;
         endcase
      end
   end

   a_no_spurious_ack: assert property (@(posedge clk) disable iff (!reset)
      !((r_state_q == R_IDLE) && ack_s && !ack_s_q));

   assign left_ack_out  = left_ack_q;
   assign right_req_out = right_req_q;
   assign data_out      = data_out_q;
   assign count         = count_q;

endmodule
